// File: rtl/parity_pkg.sv
// Shared definitions for the AXI-Stream parity scheduler:
// FSM state encoding, trailer byte layout and the byte-parity helper.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_TRAILER = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  // Trailer byte carries the parity in bit 0; the upper bits are zero.
  localparam logic [6:0] TRAILER_PAD = 7'b0000000;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins; returns one-hot grant and its index.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_IN-1:0]  gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan from farthest to nearest candidate so the nearest requester wins last.
  always_comb begin
    gnt_idx_o = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      cand_s = IDX_W'((int'(ptr_i) + k) % N_IN);
      if (req_i[cand_s]) begin
        gnt_idx_o = cand_s;
        found_s   = 1'b1;
      end else begin
        gnt_idx_o = gnt_idx_o;
      end
    end
    gnt_oh_o = found_s ? ({{(N_IN-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/axis_parity_scheduler.sv
// Packet-granular round-robin scheduler sharing one parity datapath between
// N_IN byte streams; forwards each packet and appends a parity trailer byte.
module axis_parity_scheduler
  import parity_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 16
) (
  input  logic                      in_clock,
  input  logic                      axis_aresetn,
  input  logic [N_IN-1:0]           axis_s_tvalid,
  input  logic [N_IN*8-1:0]         axis_s_tdata,
  input  logic [N_IN-1:0]           axis_s_tlast,
  output logic [N_IN-1:0]           axis_s_tready,
  output logic                      axis_m_tvalid,
  output logic [7:0]                axis_m_tdata,
  output logic                      axis_m_tlast,
  input  logic                      axis_m_tready,
  output logic [$clog2(N_IN)-1:0]   grant_idx,
  output logic                      busy,
  output logic [CNT_W-1:0]          pkt_count
);

  localparam int   IDX_W   = $clog2(N_IN);
  localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             acc_q, acc_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_IN-1:0]  arb_oh_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             slot_free_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic [7:0]       sel_data_s;

  rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W)) u_arb (
    .req_i     (axis_s_tvalid),
    .ptr_i     (rr_q),
    .gnt_oh_o  (arb_oh_s),
    .gnt_idx_o (arb_idx_s)
  );

  assign slot_free_s = !m_valid_q || axis_m_tready;
  assign sel_valid_s = axis_s_tvalid[grant_q];
  assign sel_last_s  = axis_s_tlast[grant_q];
  assign sel_data_s  = axis_s_tdata[8*grant_q +: 8];

  // Next-state logic; an unreloaded output slot empties once the consumer takes it.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    m_valid_d     = m_valid_q & ~axis_m_tready;
    axis_s_tready = '0;
    case (state_q)
      ST_IDLE: begin
        if (|arb_oh_s) begin
          grant_d = arb_idx_s;
          acc_d   = 1'b0;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        axis_s_tready[grant_q] = slot_free_s;
        if (sel_valid_s && slot_free_s) begin
          m_data_d  = sel_data_s;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          acc_d     = acc_q ^ byte_parity(sel_data_s);
          state_d   = sel_last_s ? ST_TRAILER : ST_STREAM;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_TRAILER: begin
        if (slot_free_s) begin
          m_data_d  = {TRAILER_PAD, acc_q ^ ODD_BIT};
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_TRAILER;
        end
      end
      ST_WAIT: begin
        if (m_valid_q && axis_m_tready && m_last_q) begin
          cnt_d   = cnt_q + CNT_W'(1);
          rr_d    = (grant_q == IDX_W'(N_IN - 1)) ? '0 : grant_q + IDX_W'(1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, output slot and counters.
  always_ff @(posedge in_clock or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign axis_m_tvalid = m_valid_q;
  assign axis_m_tdata  = m_data_q;
  assign axis_m_tlast  = m_last_q;
  assign grant_idx     = grant_q;
  assign pkt_count     = cnt_q;
  assign busy          = (state_q == ST_STREAM) || (state_q == ST_TRAILER);

endmodule

// File: tb/tb_axis_parity_scheduler.sv
// Randomized bench for axis_parity_scheduler: per-source packet queues drive the
// inputs, a packet-level round-robin model predicts the master byte stream.
module tb_axis_parity_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     s_tvalid, s_tlast, s_tready, o_s_tready;
  logic [N*8-1:0]   s_tdata;
  logic             m_tvalid, m_tlast, m_tready;
  logic [7:0]       m_tdata;
  logic             o_tvalid, o_tlast;
  logic [7:0]       o_tdata;
  logic [1:0]       grant_idx, o_grant;
  logic             busy, o_busy;
  logic [15:0]      pkt_count;
  logic [1:0]       o_count;

  always #5 clk = ~clk;

  axis_parity_scheduler #(.N_IN(N), .PARITY_ODD(0), .CNT_W(16)) dut (
    .in_clock(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(s_tready),
    .axis_m_tvalid(m_tvalid), .axis_m_tdata(m_tdata), .axis_m_tlast(m_tlast),
    .axis_m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  // Odd-parity variant with a 2-bit counter so wrap-around is reached quickly.
  axis_parity_scheduler #(.N_IN(N), .PARITY_ODD(1), .CNT_W(2)) dut_odd (
    .in_clock(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(o_s_tready),
    .axis_m_tvalid(o_tvalid), .axis_m_tdata(o_tdata), .axis_m_tlast(o_tlast),
    .axis_m_tready(m_tready),
    .grant_idx(o_grant), .busy(o_busy), .pkt_count(o_count)
  );

  logic [8:0] src_q [N][$];   // {last, data} still to be offered per source
  logic [8:0] mq    [N][$];   // model copy, consumed by plan()
  logic [8:0] exp_q [$];      // expected master beats {last, data}
  int         exp_src [$];    // expected source of each packet, in order
  int         exp_cnt, mdl_ptr, total, bad, rdy_mode;
  int         sent [N];
  logic [N-1:0] hs_s, mid, hold;
  logic       hs_m, gap_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int pending_src();
    int n = 0;
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  function automatic int pending_mq();
    int n = 0;
    for (int i = 0; i < N; i++) n += mq[i].size();
    return n;
  endfunction

  task automatic load(input int src, input logic [7:0] d, input logic l);
    src_q[src].push_back({l, d});
    mq[src].push_back({l, d});
  endtask

  // Packet-level round robin: every loaded packet is pending from the start.
  task automatic plan();
    logic [8:0] e;
    int s, ones, c;
    while (pending_mq() > 0) begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        c = (mdl_ptr + k) % N;
        if (s < 0 && mq[c].size() > 0) s = c;
      end
      ones = 0;
      do begin
        e = mq[s].pop_front();
        exp_q.push_back({1'b0, e[7:0]});
        ones += $countones(e[7:0]);
      end while (!e[8]);
      exp_q.push_back({1'b1, 7'b0000000, (ones % 2 == 1)});
      exp_src.push_back(s);
      mdl_ptr = (s + 1) % N;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    exp_src.delete();
    hs_s = '0; hs_m = 1'b0; mid = '0; hold = '0;
    exp_cnt = 0; mdl_ptr = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 8'h00);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_s_tready", s_tready, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_idx, 2'd0);
    chk("rst_count", pkt_count, 16'd0);
    chk("rst_odd_tvalid", o_tvalid, 1'b0);
    flush();
    @(negedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || pending_src() > 0) && n < 3000) begin
      @(negedge clk); #3;
      n++;
    end
    chk({tag, "_timeout"}, (n < 3000), 1'b1);
    if (n >= 3000) begin
      @(negedge clk); #3;
      reset_dut();
    end
    repeat (3) @(negedge clk);
    #3;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_odd_busy"}, o_busy, 1'b0);
  endtask

  // Source/sink driver and output monitor, one step per clock.
  initial begin : drive
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hs_s[i] && src_q[i].size() > 0) begin
          e = src_q[i].pop_front();
          mid[i] = ~e[8];
          sent[i]++;
        end
      end
      if (hs_m && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[8]) begin
          exp_cnt++;
          if (exp_src.size() > 0) void'(exp_src.pop_front());
        end
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(2) != 0);
      endcase
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && !hold[i]) begin
          e = src_q[i][0];
          s_tvalid[i] = !(mid[i] && gap_en && ($urandom_range(3) == 0));
          s_tdata[8*i +: 8] = e[7:0];
          s_tlast[i] = e[8];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tdata[8*i +: 8] = 8'h00;
          s_tlast[i] = 1'b0;
        end
      end
      #1;
      hs_s = s_tvalid & s_tready;
      hs_m = m_tvalid & m_tready;
      chk("rdy_onehot", ($countones(s_tready) <= 1), 1'b1);
      chk("odd_rdy_onehot", ($countones(o_s_tready) <= 1), 1'b1);
      chk("pkt_count", pkt_count, exp_cnt[15:0]);
      chk("pkt_count_wrap", o_count, exp_cnt[1:0]);
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", m_tvalid, 1'b0);
        end else begin
          e = exp_q[0];
          chk("m_tdata", m_tdata, e[7:0]);
          chk("m_tlast", m_tlast, e[8]);
          chk("odd_tvalid", o_tvalid, 1'b1);
          chk("odd_tdata", o_tdata, {e[7:1], e[0] ^ e[8]});
          chk("odd_tlast", o_tlast, e[8]);
          if (e[8] && exp_src.size() > 0) begin
            chk("grant_idx", grant_idx, exp_src[0]);
            chk("odd_grant", o_grant, exp_src[0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n, np, len;
    total = 0; bad = 0; rst_n = 1'b0; m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    hold = '0; mid = '0; hs_s = '0; hs_m = 1'b0;
    rdy_mode = 0; gap_en = 1'b0; exp_cnt = 0; mdl_ptr = 0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    #2;
    chk("init_m_tvalid", m_tvalid, 1'b0);
    chk("init_s_tready", s_tready, 4'h0);
    chk("init_count", pkt_count, 16'd0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Single packet from input 0: A5, 01 -> trailer 01.
    load(0, 8'hA5, 1'b0);
    load(0, 8'h01, 1'b1);
    plan();
    drain("single");
    chk("single_count", pkt_count, 16'd1);

    // One-byte FF packet: even trailer 00, odd trailer 01.
    load(3, 8'hFF, 1'b1);
    plan();
    drain("parity");

    // Inputs 0,1,2 each hold two 2-byte packets.
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) begin
        load(s, 8'($urandom), 1'b0);
        load(s, 8'($urandom), 1'b1);
      end
    plan();
    drain("rr");

    // Toggling downstream ready during a 4-byte packet.
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) load(0, 8'($urandom), (b == 3));
    plan();
    drain("bp");
    rdy_mode = 0;

    // Input 3 raises valid while input 1 is mid-packet.
    hold[3] = 1'b1;
    for (int i = 0; i < N; i++) sent[i] = 0;
    for (int p = 0; p < 3; p++) begin
      load(1, 8'($urandom), 1'b0);
      load(1, 8'($urandom), 1'b1);
    end
    load(3, 8'h3C, 1'b0);
    load(3, 8'h81, 1'b1);
    plan();
    n = 0;
    while (sent[1] < 1 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    chk("fair_start", (n < 200), 1'b1);
    hold[3] = 1'b0;
    drain("fair");

    // Reset after 2 of 5 bytes, then a clean packet from input 2.
    for (int i = 0; i < N; i++) sent[i] = 0;
    for (int b = 0; b < 5; b++) load(0, 8'($urandom), (b == 4));
    plan();
    n = 0;
    while (sent[0] < 2 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    chk("rst_mid_reach", (n < 200), 1'b1);
    reset_dut();
    for (int b = 0; b < 3; b++) load(2, 8'($urandom), (b == 2));
    plan();
    drain("post_rst");
    chk("post_rst_count", pkt_count, 16'd1);

    // Random traffic with mid-packet source gaps and random backpressure.
    gap_en = 1'b1;
    rdy_mode = 2;
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < N; s++) begin
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(5, 1);
          for (int b = 0; b < len; b++) load(s, 8'($urandom), (b == len - 1));
        end
      end
      plan();
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
